pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of non-control payload (PC, operands, immediate, register addresses, funct fields), packed by the instantiating stage.
REQ-002 Parameter CTRL_W, default 8: width of side-effect control bits (branch, reg_wena, mem_rena, mem_wena, jump, ...), forced to zero whenever a beat is killed.
REQ-003 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low: rst=0 resets immediately; rst=1 is normal operation.
REQ-006 in_valid  in  1  upstream beat present.
REQ-007 in_ready  out  1  stage accepts the upstream beat this cycle.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 in_ctrl  in  CTRL_W  upstream control bits.
REQ-010 flush  in  1  branch/jump redirect; kills all held and incoming beats.
REQ-011 bubble  in  1  load-use hazard; hold upstream and inject a NOP.
REQ-012 out_valid  out  1  downstream beat present.
REQ-013 out_ready  in  1  downstream consumes the beat this cycle.
REQ-014 out_data  out  DATA_W  held payload.
REQ-015 out_ctrl  out  CTRL_W  held control bits.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Transfers: upstream beat accepted iff in_valid && in_ready at a rising edge; downstream beat consumed iff out_valid && out_ready.
REQ-018 Base storage is one entry (main); latency from acceptance to out_valid is exactly 1 cycle.
REQ-019 Without skid: in_ready = (!out_valid || out_ready) && !bubble && !flush, combinational.
REQ-020 Simultaneous consume and accept in one cycle loads the new beat with no bubble cycle (full throughput).
REQ-021 Priority per cycle: flush > bubble > normal transfer.
REQ-022 flush=1: at the next edge all entries become invalid, out_ctrl=0, out_data=0; any incoming beat that cycle is dropped; bubble ignored.
REQ-023 bubble=1 (flush=0): upstream not accepted; if main is empty or consumed this cycle, main loads a NOP: out_valid=1, out_ctrl=0, out_data=0; otherwise main holds.
REQ-024 A NOP is an ordinary beat downstream: it requires out_ready to be consumed.
REQ-025 While out_valid=1 and out_ready=0, out_data/out_ctrl are stable until consumed or flushed.
REQ-026 out_ctrl is never nonzero while out_valid=0.
REQ-027 stall_cnt increments by 1 in each cycle with out_valid=1 && out_ready=0, saturates at all-ones, never wraps; cleared only by reset.

Reset
REQ-028 rst=0 asynchronously clears out_valid, the skid entry valid, out_data, out_ctrl, skid contents and stall_cnt to 0; no X values on any output.
REQ-029 Reset asserted mid-transfer discards all held beats; the first edge after release performs no transfer from stale state.
REQ-030 in_ready is 0 while rst=0.

Configuration
REQ-031 Macro PIPE_SKID_EN: when defined, a second (skid) entry is compiled in and in_ready = (skid empty) && !bubble && !flush, with no combinational path from out_ready to in_ready.
REQ-032 With PIPE_SKID_EN: a beat accepted while main is held and not consumed goes to skid; when main is consumed, skid moves to main at the same edge; order is strictly FIFO.
REQ-033 With PIPE_SKID_EN: flush clears both entries; a bubble NOP loads only into main, and only when skid is empty.
REQ-034 Without PIPE_SKID_EN: no skid storage exists and REQ-019 applies.

Verification
REQ-035 Streaming: out_ready=1, 4 beats with in_data=1,2,3,4 and in_ctrl=8'h0F on consecutive cycles -> out_data=1,2,3,4 on 4 consecutive cycles starting 1 cycle later, out_ctrl=8'h0F, in_ready=1 throughout.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles with main valid -> out_data stable, stall_cnt increases by 5; with PIPE_SKID_EN exactly one further beat is accepted, then in_ready=0.
REQ-037 Flush: main holds data=32'hA5, ctrl=8'hFF, plus an incoming beat; pulse flush for 1 cycle -> next cycle out_valid=0, out_ctrl=0, incoming beat never appears.
REQ-038 Bubble: bubble=1 for 1 cycle with in_valid=1, data=7 -> in_ready=0 that cycle, NOP (ctrl=0, data=0) presented, beat 7 presented on the following cycle.
REQ-039 Flush and bubble asserted in the same cycle -> flush result only, no NOP emitted.
REQ-040 Assert rst=0 between clock edges while a beat is held -> outputs go to 0 immediately; stall_cnt forced to 2^CNT_W-1 by stalling, then reset -> 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// =============================================================================
// pipe_stage_reg : valid/ready pipeline register with flush, bubble (NOP)
//                  injection and a saturating stall counter. Define
//                  PIPE_SKID_EN to add a second (skid) entry.
// Revision       : 1.0
// =============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              bubble,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_consume;
    logic w_accept;

    assign w_consume = out_valid && out_ready;
    assign w_accept  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    // Ready depends only on registered skid state, never on out_ready.
    assign in_ready = rst && !r_skid_valid && !bubble && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ctrl     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ctrl     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
        end else if (!out_valid || w_consume) begin
            if (r_skid_valid) begin
                out_valid    <= 1'b1;
                out_data     <= r_skid_data;
                out_ctrl     <= r_skid_ctrl;
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
                r_skid_ctrl  <= '0;
            end else if (bubble) begin
                out_valid <= 1'b1;
                out_data  <= '0;
                out_ctrl  <= '0;
            end else if (w_accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_ctrl  <= in_ctrl;
            end else begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end
        end else if (w_accept) begin
            // Main is stalled: park the new beat behind it.
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
            r_skid_ctrl  <= in_ctrl;
        end
    end
`else
    assign in_ready = rst && (!out_valid || out_ready) && !bubble && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else if (!out_valid || w_consume) begin
            if (bubble) begin
                out_valid <= 1'b1;
                out_data  <= '0;
                out_ctrl  <= '0;
            end else if (w_accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_ctrl  <= in_ctrl;
            end else begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 6;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [CW-1:0] in_ctrl  = '0;
    logic          flush    = 1'b0;
    logic          bubble   = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush), .bubble(bubble),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          fl;
        logic          bu;
        logic          ordy;
        logic          e_rdy;
        logic          e_ov;
        logic [DW-1:0] e_d;
        logic [CW-1:0] e_c;
    } vec_t;

    beat_t q[$];
    int    m_stall = 0;
    int    vectors = 0;
    int    miscompares = 0;
    vec_t  tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_ready();
        if (!rst || flush || bubble) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic model_step(input logic acc, input logic [DW-1:0] d, input logic [CW-1:0] c);
        int n;
        logic cons;
        n = q.size();
        cons = (n > 0) && out_ready;
        if (n > 0 && !out_ready && m_stall < (1 << NW) - 1) m_stall++;
        if (flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (bubble) begin
                if (n == 0 || (cons && n == 1)) q.push_back('0);
            end else if (acc) begin
                q.push_back({d, c});
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_data", 64'(out_data), 64'(q[0].d));
            check("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
        end else begin
            check("out_ctrl_idle", 64'(out_ctrl), 64'd0);
        end
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    endtask

    // One clock cycle: drive, check in_ready, clock, update model, check outputs.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic fl, input logic bu, input logic ordy, output logic rdy_seen);
        logic exp_rdy;
        in_valid = v; in_data = d; in_ctrl = c; flush = fl; bubble = bu; out_ready = ordy;
        #1;
        exp_rdy  = model_ready();
        rdy_seen = in_ready;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        model_step(v && exp_rdy, d, c);
        #1;
        check_outputs();
    endtask

    initial begin
        logic rdy;
        int   base;
        int   accepted;

        tbl[0]  = '{1'b1, 32'h1,  8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1,  8'h0F};
        tbl[1]  = '{1'b1, 32'h2,  8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2,  8'h0F};
        tbl[2]  = '{1'b1, 32'h3,  8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3,  8'h0F};
        tbl[3]  = '{1'b1, 32'h4,  8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4,  8'h0F};
        tbl[4]  = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h00};
        tbl[5]  = '{1'b1, 32'h7,  8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  8'h00};
        tbl[6]  = '{1'b1, 32'h7,  8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7,  8'h03};
        tbl[7]  = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h00};
        tbl[8]  = '{1'b1, 32'hA5, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5, 8'hFF};
        tbl[9]  = '{1'b1, 32'hB6, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  8'h00};
        tbl[10] = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h00};
        tbl[11] = '{1'b1, 32'h22, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 8'h44};
        tbl[12] = '{1'b1, 32'h33, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  8'h00};
        tbl[13] = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h00};
        tbl[14] = '{1'b1, 32'h55, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 8'h01};
        tbl[15] = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 8'h01};
        tbl[16] = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  8'h00};

        // Reset state
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: streaming, bubble, flush, flush+bubble, held bubble
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].fl, tbl[i].bu, tbl[i].ordy, rdy);
            check($sformatf("tbl%0d_in_ready", i), 64'(rdy), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) check($sformatf("tbl%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_d));
            check($sformatf("tbl%0d_out_ctrl", i), 64'(out_ctrl), 64'(tbl[i].e_c));
        end

        // Backpressure: 5 stalled cycles with upstream continuously offering
        cycle(1'b1, 32'h10, 8'h0F, 1'b0, 1'b0, 1'b1, rdy);
        base = m_stall;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h20 + i, 8'h0A, 1'b0, 1'b0, 1'b0, rdy);
            if (rdy) accepted++;
            check("bp_data_stable", 64'(out_data), 64'h10);
        end
        check("bp_stall_delta", 64'(stall_cnt), 64'(base + 5));
        check("bp_accepts", 64'(accepted), 64'(CAP - 1));
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, $urandom, 8'($urandom), ($urandom % 16) == 0,
                  ($urandom % 8) == 0, ($urandom % 3) != 0, rdy);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);

        // Saturate stall counter, then asynchronous reset mid-cycle
        cycle(1'b1, 32'hC3, 8'h5A, 1'b0, 1'b0, 1'b1, rdy);
        for (int i = 0; i < 70; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, rdy);
        check("stall_saturated", 64'(stall_cnt), 64'h3F);
        in_valid = 1'b1; in_data = 32'h99; in_ctrl = 8'h77;
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        m_stall = 0;
        @(posedge clk);
        #1;
        check("arst_hold_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, rdy);
        check("post_rst_no_stale", 64'(out_valid), 64'd0);
        cycle(1'b1, 32'hE1, 8'h02, 1'b0, 1'b0, 1'b1, rdy);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
